// File: rtl/fetch_pkg.sv
// Shared types and default constants for the instruction fetch unit.
// Optional FETCH_PERF_EN adds performance counters to pc_fetch_unit.
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam int          DEF_N        = 64;
    localparam int          DEF_STEP     = 4;
    localparam logic [63:0] DEF_RESET_PC = 64'd0;

    typedef struct packed {
        logic [DEF_N-1:0] pc;
        logic [DEF_N-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO buffering fetched {pc, instr} entries toward decode.
// Flush empties the queue and overrides a same-cycle push or pop.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int WIDTH     = 2 * DEF_N,
    parameter int DEPTH     = 2,
    parameter int LOG2DEPTH = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_push,
    input  logic                 i_pop,
    input  logic                 i_flush,
    input  logic [WIDTH-1:0]     i_wdata,
    output logic [WIDTH-1:0]     o_rdata,
    output logic                 o_full,
    output logic                 o_empty,
    output logic [LOG2DEPTH:0]   o_count
);

    localparam logic [LOG2DEPTH:0] FULL_CNT = (LOG2DEPTH+1)'(DEPTH);

    logic [WIDTH-1:0]     r_mem [DEPTH];
    logic [LOG2DEPTH-1:0] r_wr_ptr;
    logic [LOG2DEPTH-1:0] r_rd_ptr;
    logic [LOG2DEPTH:0]   r_count;
    logic                 w_do_push;
    logic                 w_do_pop;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; the empty flag masks stale contents,
    // which keeps the array as plain RAM-style flops without a reset network.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush && !reset) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register, req/ack instruction-memory front end and decode queue with branch redirect.
// Define FETCH_PERF_EN to add saturating perf_fetched / perf_stall counters.
module pc_fetch_unit
    import fetch_pkg::*;
#(
    parameter int             N         = DEF_N,
    parameter int             STEP      = DEF_STEP,
    parameter logic [N-1:0]   RESET_PC  = N'(DEF_RESET_PC),
    parameter int             DEPTH     = 2,
    parameter int             LOG2DEPTH = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         branch_taken,
    input  logic [N-1:0] branch_target,
    output logic         mem_req,
    output logic [N-1:0] mem_addr,
    input  logic         mem_ack,
    input  logic [N-1:0] mem_data,
    output logic         instr_valid,
    input  logic         instr_ready,
    output logic [N-1:0] instr_data,
    output logic [N-1:0] instr_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]  perf_fetched,
    output logic [31:0]  perf_stall
`endif
);

    localparam int                 CNT_W    = LOG2DEPTH + 1;
    localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(DEPTH);

    fetch_state_t     r_state;
    fetch_state_t     w_state_next;
    logic [N-1:0]     r_pc;
    logic [N-1:0]     w_pc_next;
    logic [N-1:0]     r_target;
    logic [N-1:0]     w_target_next;
    logic             r_req;
    logic             w_req_next;
    logic             w_ack;
    logic             w_pop;
    logic             w_push;
    logic             w_flush;
    logic             w_full;
    logic             w_empty;
    logic [CNT_W-1:0] w_count;
    logic [CNT_W-1:0] w_count_after;
    logic [2*N-1:0]   w_head;

    assign w_ack       = r_req && mem_ack;
    assign instr_valid = !w_empty;
    assign w_pop       = instr_valid && instr_ready;
    assign mem_req     = r_req;
    assign mem_addr    = r_pc;
    assign instr_pc    = w_head[2*N-1:N];
    assign instr_data  = w_head[N-1:0];

    fetch_queue #(
        .WIDTH     (2 * N),
        .DEPTH     (DEPTH),
        .LOG2DEPTH (LOG2DEPTH)
    ) u_queue (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_wdata ({r_pc, mem_data}),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        w_state_next  = r_state;
        w_pc_next     = r_pc;
        w_target_next = r_target;
        w_req_next    = r_req;
        w_push        = 1'b0;
        w_flush       = 1'b0;
        w_count_after = w_count;
        case (r_state)
            FETCH, HOLD: begin
                if (branch_taken) begin
                    w_flush = 1'b1;
                    // An issued request cannot be withdrawn: wait for its ack and drop it.
                    if (r_req && !mem_ack) begin
                        w_state_next  = DRAIN;
                        w_target_next = branch_target;
                    end else begin
                        w_state_next = FETCH;
                        w_pc_next    = branch_target;
                        w_req_next   = 1'b1;
                    end
                end else begin
                    w_push = w_ack && (!w_full || w_pop);
                    if (w_push) w_pc_next = r_pc + N'(STEP);
                    w_count_after = w_count + CNT_W'(w_push) - CNT_W'(w_pop);
                    w_req_next    = (r_req && !mem_ack) || (w_count_after < FULL_CNT);
                    w_state_next  = w_req_next ? FETCH : HOLD;
                end
            end
            DRAIN: begin
                if (branch_taken) w_target_next = branch_target;
                if (w_ack) begin
                    w_state_next = FETCH;
                    w_pc_next    = branch_taken ? branch_target : r_target;
                end
            end
            default: w_state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= FETCH;
            r_pc     <= RESET_PC;
            r_target <= RESET_PC;
            r_req    <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_pc     <= w_pc_next;
            r_target <= w_target_next;
            r_req    <= w_req_next;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_fetched <= '0;
            r_perf_stall   <= '0;
        end else begin
            if (w_push && (r_perf_fetched != '1))
                r_perf_fetched <= r_perf_fetched + 32'd1;
            if (!instr_valid && (r_state != HOLD) && (r_perf_stall != '1))
                r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_stall   = r_perf_stall;
`endif

endmodule
